// File: rtl/gmii_rx_frame.sv
// Receive-side GMII frame delimiter: strips preamble/SFD, re-emits frame bytes with
// start/end markers, checks CRC-32 and length, and keeps saturating good/bad frame counters.
module gmii_rx_frame #(
   parameter int unsigned MIN_LEN = 64,
   parameter int unsigned MAX_LEN = 1518
) (
   input  logic        gmii_rx_clk,
   input  logic        rst_n,
   input  logic        gmii_rx_dv,
   input  logic [7:0]  gmii_rxd,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_sof,
   output logic        rx_eof,
   output logic        rx_good,
   output logic        rx_bad,
   output logic [10:0] rx_len,
   output logic [15:0] frame_ok_cnt,
   output logic [15:0] frame_err_cnt
);

   localparam logic [10:0] MinLen     = 11'(MIN_LEN);
   localparam logic [10:0] MaxLen     = 11'(MAX_LEN);
   localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

   typedef enum logic [1:0] {StIdle, StPre, StData, StDrop} state_e;

   state_e      state;
   logic [2:0]  pre_cnt;
   logic [31:0] crc;
   logic [10:0] len;
   logic [7:0]  hold;
   logic        hold_vld;
   logic        sof_pend;
   logic [31:0] crc_next;
   logic        frame_good;

   // Reflected CRC-32, one byte, LSB first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   // crc covers every byte already emitted; the held byte is folded in here so the
   // eof cycle sees the register value after the final byte.
   assign crc_next   = crc_byte(crc, hold);
   assign frame_good = (crc_next == CrcResidue) && (len >= MinLen) && (len <= MaxLen);

   always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= StIdle;
         pre_cnt       <= 3'd0;
         crc           <= '1;
         len           <= '0;
         hold          <= '0;
         hold_vld      <= 1'b0;
         sof_pend      <= 1'b0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_sof        <= 1'b0;
         rx_eof        <= 1'b0;
         rx_good       <= 1'b0;
         rx_bad        <= 1'b0;
         rx_len        <= '0;
         frame_ok_cnt  <= '0;
         frame_err_cnt <= '0;
      end else begin
         rx_valid <= 1'b0;
         rx_sof   <= 1'b0;
         rx_eof   <= 1'b0;
         rx_good  <= 1'b0;
         rx_bad   <= 1'b0;

         if (rx_eof && rx_good && (frame_ok_cnt != 16'hFFFF)) begin
            frame_ok_cnt <= frame_ok_cnt + 16'd1;
         end
         if (rx_eof && rx_bad && (frame_err_cnt != 16'hFFFF)) begin
            frame_err_cnt <= frame_err_cnt + 16'd1;
         end

         unique case (state)
            StIdle: begin
               if (gmii_rx_dv) begin
                  if (gmii_rxd == 8'h55) begin
                     state   <= StPre;
                     pre_cnt <= 3'd1;
                  end else begin
                     state <= StDrop;
                  end
               end
            end
            StPre: begin
               if (!gmii_rx_dv) begin
                  state <= StIdle;
               end else if (gmii_rxd == 8'h55) begin
                  if (pre_cnt == 3'd7) state <= StDrop;
                  else                 pre_cnt <= pre_cnt + 3'd1;
               end else if (gmii_rxd == 8'hD5) begin
                  state    <= StData;
                  crc      <= '1;
                  len      <= '0;
                  hold_vld <= 1'b0;
                  sof_pend <= 1'b1;
               end else begin
                  state <= StDrop;
               end
            end
            StData: begin
               if (gmii_rx_dv) begin
                  if (hold_vld) begin
                     rx_valid <= 1'b1;
                     rx_data  <= hold;
                     rx_sof   <= sof_pend;
                     sof_pend <= 1'b0;
                     crc      <= crc_next;
                  end
                  hold     <= gmii_rxd;
                  hold_vld <= 1'b1;
                  if (len != 11'h7FF) len <= len + 11'd1;
               end else begin
                  // dv dropped: flush the held byte as the last of the frame, if any
                  if (hold_vld) begin
                     rx_valid <= 1'b1;
                     rx_data  <= hold;
                     rx_sof   <= sof_pend;
                     rx_eof   <= 1'b1;
                     rx_good  <= frame_good;
                     rx_bad   <= !frame_good;
                     rx_len   <= len;
                  end
                  hold_vld <= 1'b0;
                  sof_pend <= 1'b0;
                  state    <= StIdle;
               end
            end
            StDrop: begin
               if (!gmii_rx_dv) state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Bench for gmii_rx_frame: table of frame bursts plus hand-written back-to-back and
// mid-frame reset sequences; output bytes are checked against a scoreboard queue.
module tb_gmii_rx_frame;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dv = 1'b0;
   logic [7:0]  rxd = 8'h00;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_sof, rx_eof, rx_good, rx_bad;
   logic [10:0] rx_len;
   logic [15:0] frame_ok_cnt, frame_err_cnt;

   always #5 clk = ~clk;

   gmii_rx_frame #(
      .MIN_LEN(64),
      .MAX_LEN(1518)
   ) dut (
      .gmii_rx_clk  (clk),
      .rst_n        (rst_n),
      .gmii_rx_dv   (dv),
      .gmii_rxd     (rxd),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_sof       (rx_sof),
      .rx_eof       (rx_eof),
      .rx_good      (rx_good),
      .rx_bad       (rx_bad),
      .rx_len       (rx_len),
      .frame_ok_cnt (frame_ok_cnt),
      .frame_err_cnt(frame_err_cnt)
   );

   typedef struct {
      logic [7:0]  data;
      logic        sof;
      logic        eof;
      logic        good;
      logic        bad;
      logic [10:0] len;
      int          cyc;
   } exp_t;

   typedef struct {
      string name;
      int    n_pre;
      bit    junk;
      bit    sfd;
      int    len;
      bit    corrupt;
      bit    out;
      bit    good;
   } vec_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [7:0]  frm[$];
   vec_t        tbl[12];
   vec_t        g64;
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   bit          in_frame = 1'b0;
   logic [15:0] ok_exp = '0;
   logic [15:0] err_exp = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Bytes after SFD: payload i mod 256, then FCS LSB first; short frames carry no FCS.
   task automatic build_frame(input int len, input bit corrupt);
      logic [31:0] c;
      logic [7:0]  b;
      frm.delete();
      if (len < 5) begin
         for (int i = 0; i < len; i++) frm.push_back(8'(i));
      end else begin
         c = '1;
         for (int i = 0; i < len - 4; i++) begin
            b = 8'(i);
            frm.push_back(b);
            c = crc_upd(c, b);
         end
         c = ~c;
         frm.push_back(c[7:0]);
         frm.push_back(c[15:8]);
         frm.push_back(c[23:16]);
         frm.push_back(c[31:24]);
         if (corrupt) frm[10] = 8'hFF;
      end
   endtask

   task automatic drive(input logic d, input logic [7:0] b);
      @(posedge clk);
      #1;
      dv  = d;
      rxd = b;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic run_vec(input vec_t v, input int gap);
      exp_t e;
      if (v.len > 0) build_frame(v.len, v.corrupt);
      else frm.delete();
      if (v.junk) begin
         drive(1'b1, 8'h55);
         drive(1'b1, 8'h12);
      end
      for (int i = 0; i < v.n_pre; i++) drive(1'b1, 8'h55);
      if (v.sfd) drive(1'b1, 8'hD5);
      for (int k = 0; k < frm.size(); k++) begin
         drive(1'b1, frm[k]);
         if (v.out) begin
            e.data = frm[k];
            e.sof  = (k == 0);
            e.eof  = (k == frm.size() - 1);
            e.good = e.eof && v.good;
            e.bad  = e.eof && !v.good;
            e.len  = 11'(frm.size());
            e.cyc  = cyc + 2;
            exp_q.push_back(e);
         end
      end
      if (v.out && frm.size() > 0) begin
         if (v.good) ok_exp++;
         else        err_exp++;
      end
      for (int i = 0; i < gap; i++) drive(1'b0, 8'h00);
   endtask

   task automatic check_cnts(input string name);
      check({name, "_ok_cnt"}, 64'(frame_ok_cnt), 64'(ok_exp));
      check({name, "_err_cnt"}, 64'(frame_err_cnt), 64'(err_exp));
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{"good64",      7, 1'b0, 1'b1, 64,   1'b0, 1'b1, 1'b1};
      tbl[1]  = '{"bad_fcs64",   7, 1'b0, 1'b1, 64,   1'b1, 1'b1, 1'b0};
      tbl[2]  = '{"runt20",      7, 1'b0, 1'b1, 20,   1'b0, 1'b1, 1'b0};
      tbl[3]  = '{"giant1519",   7, 1'b0, 1'b1, 1519, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{"max1518",     7, 1'b0, 1'b1, 1518, 1'b0, 1'b1, 1'b1};
      tbl[5]  = '{"short63",     7, 1'b0, 1'b1, 63,   1'b0, 1'b1, 1'b0};
      tbl[6]  = '{"pre8",        8, 1'b0, 1'b1, 64,   1'b0, 1'b0, 1'b0};
      tbl[7]  = '{"pre_junk",    7, 1'b1, 1'b1, 64,   1'b0, 1'b0, 1'b0};
      tbl[8]  = '{"pre3_drop",   3, 1'b0, 1'b0, 0,    1'b0, 1'b0, 1'b0};
      tbl[9]  = '{"single_byte", 7, 1'b0, 1'b1, 1,    1'b0, 1'b1, 1'b0};
      tbl[10] = '{"sfd_drop",    7, 1'b0, 1'b1, 0,    1'b0, 1'b0, 1'b0};
      tbl[11] = '{"pre1_good",   1, 1'b0, 1'b1, 65,   1'b0, 1'b1, 1'b1};
      g64 = tbl[0];

      fork
         forever begin
            @(negedge clk);
            if (rst_n && rx_valid) begin
               tests++;
               if (in_frame && rx_sof) begin
                  fails++;
                  $display("FAIL sof_inside_frame: got sof=1 required 0");
               end
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_byte: got data=%h sof=%b eof=%b, required no output",
                           rx_data, rx_sof, rx_eof);
               end else begin
                  mon_e = exp_q.pop_front();
                  if (rx_data !== mon_e.data || rx_sof !== mon_e.sof || rx_eof !== mon_e.eof ||
                      rx_good !== mon_e.good || rx_bad !== mon_e.bad || cyc != mon_e.cyc ||
                      (mon_e.eof && rx_len !== mon_e.len)) begin
                     fails++;
                     $display("FAIL out_byte: got d=%h sof=%b eof=%b g=%b b=%b len=%0d cyc=%0d, required d=%h sof=%b eof=%b g=%b b=%b len=%0d cyc=%0d",
                              rx_data, rx_sof, rx_eof, rx_good, rx_bad, rx_len, cyc,
                              mon_e.data, mon_e.sof, mon_e.eof, mon_e.good, mon_e.bad,
                              mon_e.len, mon_e.cyc);
                  end
               end
               in_frame = rx_eof ? 1'b0 : (rx_sof ? 1'b1 : in_frame);
            end else if (rst_n) begin
               if (in_frame || rx_sof || rx_eof || rx_good || rx_bad) begin
                  tests++;
                  fails++;
                  $display("FAIL gap_or_stray: got in_frame=%b sof=%b eof=%b g=%b b=%b without valid, required none",
                           in_frame, rx_sof, rx_eof, rx_good, rx_bad);
                  in_frame = 1'b0;
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            {rx_data, rx_valid, rx_sof, rx_eof, rx_good, rx_bad, rx_len, frame_ok_cnt, frame_err_cnt},
            64'd0);
      rst_n = 1'b1;
      drive(1'b0, 8'h00);

      foreach (tbl[i]) begin
         run_vec(tbl[i], 3);
         wait_drain();
         check_cnts(tbl[i].name);
      end

      // Two good frames separated by a single dv=0 cycle.
      run_vec(g64, 1);
      run_vec(g64, 3);
      wait_drain();
      check_cnts("back_to_back");

      // Reset at byte 30 of a frame, held for two cycles while the burst continues.
      build_frame(64, 1'b0);
      for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
      drive(1'b1, 8'hD5);
      for (int k = 0; k < 64; k++) begin
         if (k == 30) begin
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            dv    = 1'b1;
            rxd   = frm[k];
            exp_q.delete();
            in_frame = 1'b0;
            ok_exp   = '0;
            err_exp  = '0;
            #1;
            check("midframe_reset_outputs",
                  {rx_data, rx_valid, rx_sof, rx_eof, rx_good, rx_bad, rx_len, frame_ok_cnt,
                   frame_err_cnt}, 64'd0);
         end else if (k == 32) begin
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            dv    = 1'b1;
            rxd   = frm[k];
         end else begin
            drive(1'b1, frm[k]);
            if (k < 30) begin
               mon_e.data = frm[k];
               mon_e.sof  = (k == 0);
               mon_e.eof  = 1'b0;
               mon_e.good = 1'b0;
               mon_e.bad  = 1'b0;
               mon_e.len  = 11'd64;
               mon_e.cyc  = cyc + 2;
               exp_q.push_back(mon_e);
            end
         end
      end
      for (int i = 0; i < 3; i++) drive(1'b0, 8'h00);
      wait_drain();
      check_cnts("after_reset_drop");
      run_vec(g64, 3);
      wait_drain();
      check_cnts("after_reset_good");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
